lsu_align: RTL and testbench

- Load/store alignment unit directly upstream of the data memory; converts execute-stage byte-addressed RISC-V load/store requests into dmem word-index accesses.
- Drives dmem's wmem byte-lane and rmem lane/sign codes.
- Performs read-modify-write for sub-word stores, because a dmem lane write zeroes the unselected bytes of the word.
- Flags misaligned, out-of-range and illegal-funct3 requests without touching memory.

---
 rtl/lsu_align_if.sv | 39 +++
 rtl/lsu_align.sv | 180 ++++++++++++++++++
 tb/tb_lsu_align.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_align_if.sv
// lsu_align_if -- bundles the execute-side request/response handshake and the
// dmem-facing access signals of the load/store alignment unit.
//   slave  : the alignment unit (consumes requests and load_data, drives the rest)
//   master : the environment (execute stage plus data memory)
// Signals:
//   req_valid/req_ready   request handshake, accept on valid && ready
//   req_store/req_funct3  direction and RISC-V size/sign code
//   req_addr/req_wdata    byte address and right-aligned store data
//   rsp_valid/rsp_err     one-cycle completion pulse and error flag
//   rsp_data              extended load result
//   wmem/rmem             dmem write lanes and {signed, read lane mask}
//   mem_addr/store_data   dmem word index and full write word
//   load_data             dmem read result
interface lsu_align_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_data;
  logic [3:0]  wmem;
  logic [4:0]  rmem;
  logic [31:0] mem_addr;
  logic [31:0] store_data;
  logic [31:0] load_data;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, load_data,
    output req_ready, rsp_valid, rsp_err, rsp_data, wmem, rmem, mem_addr, store_data
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, load_data,
    input  req_ready, rsp_valid, rsp_err, rsp_data, wmem, rmem, mem_addr, store_data
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align -- load/store alignment unit sitting directly in front of dmem.
// Turns byte-addressed RISC-V load/store requests into word-index dmem
// accesses. Sub-word stores are done as read-modify-write because a dmem lane
// write would zero the unselected bytes. Misaligned, out-of-range and
// illegal-funct3 requests complete with rsp_err and never touch memory.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : lsu_align_if.slave (request/response and dmem signals)
// Every dmem-facing output is a register, so dmem's negedge access always
// sees values that have been stable since the preceding posedge.
module lsu_align #(
  parameter int ADDR_WIDTH = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  lsu_align_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, ERR} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wmem_q, wmem_d;
  logic [4:0]  rmem_q, rmem_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] store_data_q, store_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [3:0]  lane_q, lane_d;    // lanes to replace during RMW
  logic [31:0] wdata_q, wdata_d;  // store data replicated across all lanes

  // Request decode, only meaningful in IDLE.
  logic [1:0]  off;
  logic [3:0]  lane;
  logic        sign;
  logic        f3_ok;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;
  logic [31:0] merged;

  assign off          = bus.req_addr[1:0];
  assign out_of_range = |bus.req_addr[31:ADDR_WIDTH+2];
  assign req_err      = !f3_ok || misaligned || out_of_range;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    lane       = 4'b0000;
    f3_ok      = 1'b0;
    misaligned = 1'b0;
    sign       = 1'b0;
    case (bus.req_funct3[1:0])
      2'b00:   lane = 4'b0001 << off;
      2'b01:   lane = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   lane = 4'b1111;
      default: lane = 4'b0000;
    endcase
    if (bus.req_store)
      f3_ok = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
    else
      f3_ok = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    misaligned = ((bus.req_funct3[1:0] == 2'b01) && off[0]) ||
                 ((bus.req_funct3[1:0] == 2'b10) && (off != 2'b00));
    sign = !bus.req_store && (bus.req_funct3 inside {3'b000, 3'b001});
  end

  // Selected lanes come from the replicated store data, the rest keep the
  // word just read from dmem.
  always_comb begin
    merged = '0;
    for (int i = 0; i < 4; i++)
      merged[8*i +: 8] = lane_q[i] ? wdata_q[8*i +: 8] : bus.load_data[8*i +: 8];
  end

  always_comb begin
    state_d      = state_q;
    wmem_d       = wmem_q;
    rmem_d       = rmem_q;
    mem_addr_d   = mem_addr_q;
    store_data_d = store_data_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    // Response fields are pulses: they fall back to zero unless set below.
    rsp_valid_d  = 1'b0;
    rsp_err_d    = 1'b0;
    rsp_data_d   = '0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_err) begin
            state_d = ERR;
          end else begin
            mem_addr_d = {2'b00, bus.req_addr[31:2]};
            if (!bus.req_store) begin
              rmem_d  = {sign, lane};
              state_d = LOAD;
            end else if (bus.req_funct3 == 3'b010) begin
              wmem_d       = 4'b1111;
              store_data_d = bus.req_wdata;
              state_d      = STORE;
            end else begin
              rmem_d  = 5'b01111;
              lane_d  = lane;
              wdata_d = bus.req_funct3[0] ? {2{bus.req_wdata[15:0]}}
                                          : {4{bus.req_wdata[7:0]}};
              state_d = RMW_RD;
            end
          end
        end
      end
      LOAD: begin
        rsp_data_d  = bus.load_data;
        rmem_d      = 5'b00000;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      STORE: begin
        wmem_d      = 4'b0000;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      RMW_RD: begin
        store_data_d = merged;
        wmem_d       = 4'b1111;
        rmem_d       = 5'b00000;
        state_d      = RMW_WR;
      end
      RMW_WR: begin
        wmem_d      = 4'b0000;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      ERR: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wmem_q       <= '0;
      rmem_q       <= '0;
      mem_addr_q   <= '0;
      store_data_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_data_q   <= '0;
      lane_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      wmem_q       <= wmem_d;
      rmem_q       <= rmem_d;
      mem_addr_q   <= mem_addr_d;
      store_data_q <= store_data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_data_q   <= rsp_data_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.wmem       = wmem_q;
  assign bus.rmem       = rmem_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.store_data = store_data_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_lsu_align.sv
// tb_lsu_align -- directed self-checking bench for lsu_align. A small dmem
// model reads and writes on the negedge using the rmem/wmem codes; all
// expected values are hand-computed constants.
module tb_lsu_align;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  lsu_align_if bus();

  lsu_align #(.ADDR_WIDTH(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // dmem model: lane extraction and sign extension happen on the read side.
  logic [31:0] mem [256];

  function automatic logic [31:0] dmem_read(input logic [31:0] w, input logic [4:0] code);
    logic [31:0] r;
    r = 32'h0;
    case (code[3:0])
      4'b0001: r = code[4] ? {{24{w[7]}},  w[7:0]}   : {24'h0, w[7:0]};
      4'b0010: r = code[4] ? {{24{w[15]}}, w[15:8]}  : {24'h0, w[15:8]};
      4'b0100: r = code[4] ? {{24{w[23]}}, w[23:16]} : {24'h0, w[23:16]};
      4'b1000: r = code[4] ? {{24{w[31]}}, w[31:24]} : {24'h0, w[31:24]};
      4'b0011: r = code[4] ? {{16{w[15]}}, w[15:0]}  : {16'h0, w[15:0]};
      4'b1100: r = code[4] ? {{16{w[31]}}, w[31:16]} : {16'h0, w[31:16]};
      4'b1111: r = w;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (bus.rmem != 5'b00000)
      bus.load_data = dmem_read(mem[bus.mem_addr[7:0]], bus.rmem);
    if (bus.wmem == 4'b1111)
      mem[bus.mem_addr[7:0]] = bus.store_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for exactly one accept edge, leaving the bench
  // #1 after the accept edge.
  task automatic issue(input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    step();
    bus.req_valid  = 1'b0;
  endtask

  task automatic load_case(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] exp_maddr, input logic [4:0] exp_rmem,
                           input logic [31:0] exp_data);
    issue(1'b0, f3, addr, 32'h0);
    check({tag, "_rmem"}, {27'h0, bus.rmem}, {27'h0, exp_rmem});
    check({tag, "_maddr"}, bus.mem_addr, exp_maddr);
    check({tag, "_busy"}, {31'h0, bus.req_ready}, 32'h0);
    step();
    check({tag, "_vld_err"}, {30'h0, bus.rsp_valid, bus.rsp_err}, 32'h2);
    check({tag, "_data"}, bus.rsp_data, exp_data);
    check({tag, "_rmem_clr"}, {27'h0, bus.rmem}, 32'h0);
  endtask

  task automatic err_case(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr);
    issue(st, f3, addr, 32'hFFFF_FFFF);
    check({tag, "_mem_idle0"}, {23'h0, bus.wmem, bus.rmem}, 32'h0);
    check({tag, "_no_vld_yet"}, {31'h0, bus.rsp_valid}, 32'h0);
    step();
    check({tag, "_vld_err"}, {30'h0, bus.rsp_valid, bus.rsp_err}, 32'h3);
    check({tag, "_data"}, bus.rsp_data, 32'h0);
    check({tag, "_mem_idle1"}, {23'h0, bus.wmem, bus.rmem}, 32'h0);
    step();
    check({tag, "_vld_clr"}, {30'h0, bus.rsp_valid, bus.rsp_err}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40]     = 32'h8899_AABB;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.load_data  = 32'h0;

    // Reset state; a request held during reset must be ignored.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h100;
    bus.req_funct3 = 3'b010;
    step();
    step();
    check("rst_ctl", {23'h0, bus.wmem, bus.rmem}, 32'h0);
    check("rst_rsp", {30'h0, bus.rsp_valid, bus.rsp_err}, 32'h0);
    check("rst_maddr", bus.mem_addr, 32'h0);
    check("rst_sdata", bus.store_data, 32'h0);
    check("rst_rdata", bus.rsp_data, 32'h0);
    check("rst_ready", {31'h0, bus.req_ready}, 32'h1);
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // Loads of each size and sign.
    load_case("lw100",  3'b010, 32'h100, 32'h40, 5'b01111, 32'h8899_AABB);
    load_case("lb102",  3'b000, 32'h102, 32'h40, 5'b10100, 32'hFFFF_FF99);
    load_case("lbu103", 3'b100, 32'h103, 32'h40, 5'b01000, 32'h0000_0088);
    load_case("lh102",  3'b001, 32'h102, 32'h40, 5'b11100, 32'hFFFF_8899);
    load_case("lhu100", 3'b101, 32'h100, 32'h40, 5'b00011, 32'h0000_AABB);

    // sb 0x101: read-modify-write.
    issue(1'b1, 3'b000, 32'h101, 32'h0000_0012);
    check("sb_rd_rmem", {27'h0, bus.rmem}, 32'h0F);
    check("sb_rd_wmem", {28'h0, bus.wmem}, 32'h0);
    check("sb_rd_maddr", bus.mem_addr, 32'h40);
    step();
    check("sb_wr_wmem", {28'h0, bus.wmem}, 32'hF);
    check("sb_wr_rmem", {27'h0, bus.rmem}, 32'h0);
    check("sb_wr_sdata", bus.store_data, 32'h8899_12BB);
    check("sb_wr_novld", {31'h0, bus.rsp_valid}, 32'h0);
    step();
    check("sb_done_vld", {30'h0, bus.rsp_valid, bus.rsp_err}, 32'h2);
    check("sb_done_wmem", {28'h0, bus.wmem}, 32'h0);
    check("sb_done_data", bus.rsp_data, 32'h0);
    load_case("lw_after_sb", 3'b010, 32'h100, 32'h40, 5'b01111, 32'h8899_12BB);

    // sh 0x102: upper half replaced.
    issue(1'b1, 3'b001, 32'h102, 32'hABCD_7766);
    step();
    check("sh_wr_sdata", bus.store_data, 32'h7766_12BB);
    step();
    check("sh_done_vld", {31'h0, bus.rsp_valid}, 32'h1);
    load_case("lw_after_sh", 3'b010, 32'h100, 32'h40, 5'b01111, 32'h7766_12BB);

    // Error requests.
    err_case("sh103",  1'b1, 3'b001, 32'h103);
    err_case("sw102",  1'b1, 3'b010, 32'h102);
    err_case("lw_oor", 1'b0, 3'b010, 32'h0004_0000);
    err_case("ld_f3",  1'b0, 3'b011, 32'h100);
    err_case("st_f3",  1'b1, 3'b100, 32'h100);
    check("err_mem_intact", mem[8'h40], 32'h7766_12BB);

    // Back-to-back with req_valid held high.
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h100;
    step();
    check("b2b_e1_ready", {31'h0, bus.req_ready}, 32'h0);
    bus.req_store  = 1'b1;
    bus.req_addr   = 32'h104;
    bus.req_wdata  = 32'hDEAD_BEEF;
    step();
    check("b2b_e2_ready", {31'h0, bus.req_ready}, 32'h1);
    check("b2b_e2_vld", {31'h0, bus.rsp_valid}, 32'h1);
    check("b2b_e2_data", bus.rsp_data, 32'h7766_12BB);
    step();
    check("b2b_e3_ready", {31'h0, bus.req_ready}, 32'h0);
    check("b2b_e3_wmem", {28'h0, bus.wmem}, 32'hF);
    check("b2b_e3_sdata", bus.store_data, 32'hDEAD_BEEF);
    check("b2b_e3_maddr", bus.mem_addr, 32'h41);
    bus.req_store  = 1'b0;
    step();
    check("b2b_e4_ready", {31'h0, bus.req_ready}, 32'h1);
    check("b2b_e4_vld", {31'h0, bus.rsp_valid}, 32'h1);
    check("b2b_e4_data", bus.rsp_data, 32'h0);
    step();
    bus.req_valid = 1'b0;
    check("b2b_e5_ready", {31'h0, bus.req_ready}, 32'h0);
    check("b2b_e5_rmem", {27'h0, bus.rmem}, 32'h0F);
    step();
    check("b2b_e6_vld", {31'h0, bus.rsp_valid}, 32'h1);
    check("b2b_e6_data", bus.rsp_data, 32'hDEAD_BEEF);

    // Reset during RMW_WR before the write negedge.
    issue(1'b1, 3'b000, 32'h100, 32'h0000_0055);
    step();
    check("rst_rmw_wmem_pre", {28'h0, bus.wmem}, 32'hF);
    rst_n = 1'b0;
    #1;
    check("rst_rmw_wmem", {28'h0, bus.wmem}, 32'h0);
    check("rst_rmw_ready", {31'h0, bus.req_ready}, 32'h1);
    step();
    check("rst_rmw_novld", {31'h0, bus.rsp_valid}, 32'h0);
    check("rst_rmw_mem", mem[8'h40], 32'h7766_12BB);
    rst_n = 1'b1;
    step();
    check("rst_rmw_novld2", {31'h0, bus.rsp_valid}, 32'h0);
    load_case("lw_after_rst", 3'b010, 32'h100, 32'h40, 5'b01111, 32'h7766_12BB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
